// File: rtl/clause_scan_controller.sv
// Sweeps the static clause memory once per request, handing each row slice to the
// clause evaluator over valid/ready and folding per-row verdicts into one result.
module clause_scan_controller #(
  parameter int NUM_ROWS  = 4,
  parameter int PTR_BITS  = 2,
  parameter int PASS_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 eval_ready,
  input  logic                 row_sat,
  input  logic                 row_conflict,
  output logic [PTR_BITS-1:0]  row_ptr,
  output logic                 slice_valid,
  output logic                 last_row,
  output logic                 busy,
  output logic                 done,
  output logic                 result_sat,
  output logic                 result_conflict,
  output logic [PASS_BITS-1:0] pass_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PTR_BITS-1:0]  LAST_PTR = PTR_BITS'(NUM_ROWS - 1);
  localparam logic [PASS_BITS-1:0] PASS_MAX = {PASS_BITS{1'b1}};

  state_t               state_r, state_s;
  logic [PTR_BITS-1:0]  row_ptr_r, row_ptr_s;
  logic                 slice_valid_r, slice_valid_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 result_sat_r, result_sat_s;
  logic                 result_conflict_r, result_conflict_s;
  logic [PASS_BITS-1:0] pass_count_r, pass_count_s;
  logic                 accept_s;
  logic                 acc_sat_s;
  logic                 acc_conflict_s;
  logic                 ptr_is_last_s;

  assign accept_s       = slice_valid_r & eval_ready;
  assign acc_sat_s      = result_sat_r & row_sat;
  assign acc_conflict_s = result_conflict_r | row_conflict;
  assign ptr_is_last_s  = (row_ptr_r == LAST_PTR);

  // Next-state and next-output decode for the scan sequencer
  always_comb begin
    state_s           = state_r;
    row_ptr_s         = row_ptr_r;
    slice_valid_s     = 1'b0;
    busy_s            = 1'b0;
    done_s            = 1'b0;
    result_sat_s      = result_sat_r;
    result_conflict_s = result_conflict_r;
    pass_count_s      = pass_count_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        row_ptr_s = {PTR_BITS{1'b0}};
        if (start) begin
          // Sat accumulator seeds to 1 so the AND-fold starts neutral
          state_s           = ST_SCAN;
          slice_valid_s     = 1'b1;
          busy_s            = 1'b1;
          result_sat_s      = 1'b1;
          result_conflict_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          // Abort wins over a same-cycle accept; that verdict is dropped
          state_s           = ST_IDLE;
          row_ptr_s         = {PTR_BITS{1'b0}};
          result_sat_s      = 1'b0;
          result_conflict_s = 1'b0;
        end else if (accept_s) begin
          if (row_conflict || ptr_is_last_s) begin
            state_s           = ST_DONE;
            row_ptr_s         = {PTR_BITS{1'b0}};
            done_s            = 1'b1;
            result_sat_s      = acc_sat_s & ~acc_conflict_s;
            result_conflict_s = acc_conflict_s;
            if (pass_count_r != PASS_MAX) begin
              pass_count_s = pass_count_r + {{(PASS_BITS-1){1'b0}}, 1'b1};
            end else begin
              pass_count_s = pass_count_r;
            end
          end else begin
            row_ptr_s         = row_ptr_r + {{(PTR_BITS-1){1'b0}}, 1'b1};
            slice_valid_s     = 1'b1;
            busy_s            = 1'b1;
            result_sat_s      = acc_sat_s;
            result_conflict_s = acc_conflict_s;
          end
        end else begin
          slice_valid_s = 1'b1;
          busy_s        = 1'b1;
        end
      end
      default: begin
        state_s           = ST_IDLE;
        row_ptr_s         = {PTR_BITS{1'b0}};
        result_sat_s      = 1'b0;
        result_conflict_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r           <= ST_IDLE;
      row_ptr_r         <= {PTR_BITS{1'b0}};
      slice_valid_r     <= 1'b0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      result_sat_r      <= 1'b0;
      result_conflict_r <= 1'b0;
      pass_count_r      <= {PASS_BITS{1'b0}};
    end else begin
      state_r           <= state_s;
      row_ptr_r         <= row_ptr_s;
      slice_valid_r     <= slice_valid_s;
      busy_r            <= busy_s;
      done_r            <= done_s;
      result_sat_r      <= result_sat_s;
      result_conflict_r <= result_conflict_s;
      pass_count_r      <= pass_count_s;
    end
  end

  assign row_ptr         = row_ptr_r;
  assign slice_valid     = slice_valid_r;
  assign last_row        = slice_valid_r & ptr_is_last_s;
  assign busy            = busy_r;
  assign done            = done_r;
  assign result_sat      = result_sat_r;
  assign result_conflict = result_conflict_r;
  assign pass_count      = pass_count_r;

endmodule

// File: tb/tb_clause_scan_controller.sv
// Directed self-checking bench for clause_scan_controller (NUM_ROWS=4, PASS_BITS=2
// so pass-count saturation is reachable).
module tb_clause_scan_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       eval_ready;
  logic       row_sat;
  logic       row_conflict;
  logic [1:0] row_ptr;
  logic       slice_valid;
  logic       last_row;
  logic       busy;
  logic       done;
  logic       result_sat;
  logic       result_conflict;
  logic [1:0] pass_count;

  int checks_s;
  int failures_s;

  clause_scan_controller #(
    .NUM_ROWS (4),
    .PTR_BITS (2),
    .PASS_BITS(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .eval_ready     (eval_ready),
    .row_sat        (row_sat),
    .row_conflict   (row_conflict),
    .row_ptr        (row_ptr),
    .slice_valid    (slice_valid),
    .last_row       (last_row),
    .busy           (busy),
    .done           (done),
    .result_sat     (result_sat),
    .result_conflict(result_conflict),
    .pass_count     (pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks_s++;
    if (obs != exp) begin
      failures_s++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input int sat, input int conf, input int pc);
    check_val({tag, "_sv"},   slice_valid, 0);
    check_val({tag, "_ptr"},  row_ptr, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_sat"},  result_sat, sat);
    check_val({tag, "_conf"}, result_conflict, conf);
    check_val({tag, "_pc"},   pass_count, pc);
  endtask

  initial begin
    checks_s     = 0;
    failures_s   = 0;
    reset        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    eval_ready   = 1'b0;
    row_sat      = 1'b0;
    row_conflict = 1'b0;
    tick();
    tick();
    check_idle_outputs("rst", 0, 0, 0);
    check_val("rst_last", last_row, 0);
    reset = 1'b1;
    tick();

    // Nominal full sweep
    start = 1'b1; eval_ready = 1'b1; row_sat = 1'b1;
    tick();
    start = 1'b0;
    check_val("nom_sv0", slice_valid, 1);
    check_val("nom_busy", busy, 1);
    for (int r = 0; r < 4; r++) begin
      check_val("nom_ptr", row_ptr, r);
      check_val("nom_last", last_row, (r == 3) ? 1 : 0);
      check_val("nom_nodone", done, 0);
      if (r < 3) tick();
    end
    tick();
    check_val("nom_done", done, 1);
    check_val("nom_sv_done", slice_valid, 0);
    check_val("nom_sat", result_sat, 1);
    check_val("nom_conf", result_conflict, 0);
    check_val("nom_pc", pass_count, 1);
    tick();
    check_idle_outputs("nom_idle", 1, 0, 1);

    // Stall on row 1 for two cycles, then on row 3 for two cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("stl_ptr0", row_ptr, 0);
    tick();
    check_val("stl_ptr1a", row_ptr, 1);
    eval_ready = 1'b0;
    tick();
    check_val("stl_ptr1b", row_ptr, 1);
    tick();
    check_val("stl_ptr1c", row_ptr, 1);
    check_val("stl_sv", slice_valid, 1);
    eval_ready = 1'b1;
    tick();
    check_val("stl_ptr2", row_ptr, 2);
    tick();
    check_val("stl_ptr3", row_ptr, 3);
    eval_ready = 1'b0;
    tick();
    check_val("stl_last_a", last_row, 1);
    check_val("stl_ptr3b", row_ptr, 3);
    tick();
    check_val("stl_last_b", last_row, 1);
    check_val("stl_nodone", done, 0);
    eval_ready = 1'b1;
    tick();
    check_val("stl_done", done, 1);
    check_val("stl_pc", pass_count, 2);
    tick();

    // Early conflict on row 1
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("cfl_ptr0", row_ptr, 0);
    tick();
    check_val("cfl_ptr1", row_ptr, 1);
    row_conflict = 1'b1; row_sat = 1'b0;
    tick();
    row_conflict = 1'b0; row_sat = 1'b1;
    check_val("cfl_done", done, 1);
    check_val("cfl_sv", slice_valid, 0);
    check_val("cfl_conf", result_conflict, 1);
    check_val("cfl_sat", result_sat, 0);
    check_val("cfl_pc", pass_count, 3);
    tick();
    check_idle_outputs("cfl_idle", 0, 1, 3);

    // Abort together with the accept of row 2
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_val("abt_ptr2", row_ptr, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("abt", 0, 0, 3);
    tick();
    check_val("abt_nodone", done, 0);

    // Clean sweep after abort; pass_count already saturated at 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      check_val("aft_ptr", row_ptr, r);
      tick();
    end
    check_val("aft_done", done, 1);
    check_val("aft_sat", result_sat, 1);
    check_val("aft_conf", result_conflict, 0);
    check_val("aft_pc", pass_count, 3);
    tick();

    // Asynchronous reset during row 2
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_val("mrs_ptr2", row_ptr, 2);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("mrs", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("mrs_nodone", done, 0);
    end
    reset = 1'b1;
    tick();

    // Back-to-back sweeps with start held: bubble per sweep, saturating count
    start = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      tick();
      check_val("b2b_sv", slice_valid, 1);
      check_val("b2b_ptr0", row_ptr, 0);
      tick();
      tick();
      tick();
      check_val("b2b_ptr3", row_ptr, 3);
      tick();
      check_val("b2b_done", done, 1);
      check_val("b2b_bubble", slice_valid, 0);
      check_val("b2b_pc", pass_count, (s < 3) ? s : 3);
    end
    start = 1'b0;
    tick();
    check_idle_outputs("b2b_idle", 1, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
